rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares the single combinational instruction ROM between the core's instruction-fetch port and its data-load port, so `.rodata` constants can be read from ROM without a second copy. It sits between the core and the ROM instance inside the SoC core. It grants one requester per cycle and registers the ROM word with one cycle of latency. A starvation guard prevents continuous fetch traffic from locking out data loads.

## Interface
- `ADDR_W`, 12: byte-address width of both request ports and the ROM address.
- `DEPTH`, 128: ROM depth in 32-bit words. Valid byte addresses are `0 .. 4*DEPTH-1`.
- `MAX_WAIT`, 4: maximum number of consecutive denied cycles for a pending data request before it gets priority. Range 1–15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until granted.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_rvalid`  out  1  fetch data valid; one-cycle pulse.
- `if_rdata`  out  32  fetch data.
- `dm_req`  in  1  data-load request; held with `dm_addr` until granted.
- `dm_addr`  in  ADDR_W  data-load byte address.
- `dm_gnt`  out  1  data load accepted this cycle (combinational).
- `dm_rvalid`  out  1  data-load response valid; one-cycle pulse.
- `dm_rdata`  out  32  data-load data.
- `dm_err`  out  1  qualifies `dm_rvalid`: misaligned or out-of-range access.
- `rom_addr`  out  ADDR_W  address driven to the ROM.
- `rom_inst`  in  32  combinational ROM word for `rom_addr`.

## Operation
- Arbitration runs each cycle over `if_req` and `dm_req`. At most one of `if_gnt`/`dm_gnt` is high.
- **Default priority:** fetch wins.
- **Starvation guard:** counter `wait_cnt` (4 bits).
  - Increments in any cycle where `dm_req && !dm_gnt`.
  - Clears on `dm_gnt` or when `dm_req` is low.
  - When `wait_cnt == MAX_WAIT`, data wins that cycle even if `if_req` is high; `if_gnt` is low.
- **ROM address:** `rom_addr` = granted requester's address; `if_addr` when neither is granted. The address is forwarded unmodified; the ROM ignores bits [1:0].
- **Fetch range check:** a fetch with `if_addr >= 4*DEPTH` returns `if_rdata = 32'h00000013` (NOP) and raises no error flag.
- **Data error check:** a data access is an error if `dm_addr[1:0] != 0` or `dm_addr >= 4*DEPTH`. The response is then `dm_err = 1`, `dm_rdata = 0`.
- **Response register:** a granted request captures `rom_inst` (or the substitute value) into that port's data register.
  - The port's `rvalid` pulses the next cycle.
  - `rdata` holds its value until that port's next response.
- **Controller state:** `grant_q ∈ {NONE, IF, DM}` records last cycle's grant and drives `rvalid`. Transitions:
  - any state → IF on `if_gnt`
  - → DM on `dm_gnt`
  - → NONE otherwise

## Timing
- Grant is combinational in cycle N. Data and `rvalid` are registered at N+1.
- Back-to-back grants on either port are allowed, giving one response per cycle throughput.
- Both requests can be high for the same cycle: only one is granted. The loser stays pending and its `wait_cnt` increments.
- When `reset_n` is low at an edge:
  - `grant_q = NONE` and `wait_cnt = 0`.
  - `if_rvalid`, `dm_rvalid` and `dm_err` are all 0.
  - `if_rdata = 32'h00000013`; `dm_rdata = 0`.
- Reset mid-operation drops any in-flight response. No `rvalid` is produced for a request granted in the reset cycle.
- Grants are still driven combinationally while `reset_n` is low, but they have no effect.

## Structure
- Shared package `soc_pkg`:
  - `typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_DM} rom_gnt_e`
  - `localparam logic [31:0] RV_NOP = 32'h00000013`
- One sub-module is natural: `rom_starve_cnt`. It holds the saturating `wait_cnt` and outputs `force_dm`.
- The ROM itself stays a separate instance. The arbiter contains no storage beyond its response registers.

## Test plan
- **Fetch only:** `if_req=1` with addresses 0, 4, 8 on consecutive cycles → three `if_gnt` pulses. `if_rvalid` in cycles 1–3 with the ROM words at indices 0, 1, 2. `dm_rvalid` stays 0.
- **Data only:** `dm_req=1`, `dm_addr=12'h008` → `dm_gnt` in cycle 0. In cycle 1, `dm_rvalid=1`, `dm_err=0` and `dm_rdata` equals ROM word 2.
- **Contention with starvation:** `if_req` held high and `dm_req` raised with `MAX_WAIT=4`.
  - Fetch is granted for 4 cycles.
  - The 5th cycle gives `dm_gnt=1` and `if_gnt=0`.
  - Fetch resumes the next cycle and `wait_cnt` returns to 0.
- **Errors:**
  - `dm_addr=12'h006` → `dm_err=1`, `dm_rdata=0`.
  - `dm_addr=12'h200` (DEPTH=128) → `dm_err=1`.
  - `if_addr=12'h200` → `if_rdata=32'h00000013`.
- **Reset mid-operation:** grant a data load, then assert `reset_n=0` on the next edge → no `dm_rvalid`, `dm_rdata=0`, `if_rdata=32'h00000013`. After release, the first fetch responds normally.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC types and constants used by the ROM port arbiter.
package soc_pkg;

  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_DM} rom_gnt_e;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  // Data-port response word: error flag travels with the data it qualifies.
  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } dm_resp_t;

endpackage

// File: rtl/rom_starve_cnt.sv
// Saturating wait counter for a pending data load; force_dm gives data priority after MAX_WAIT denials.
// Registered count, combinational force_dm; the count clears whenever the request is granted or withdrawn.
module rom_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dm_req,
  input  logic dm_gnt,
  output logic force_dm
);

  logic [3:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!dm_req || dm_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign force_dm = (wait_cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM between fetch and data-load ports; fetch wins unless a load has starved.
// Grant is combinational, response one cycle later; a denied requester holds its request until granted.
module rom_port_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  logic        force_dm;
  logic        if_oor;
  logic        dm_bad;
  rom_gnt_e    grant_q;
  logic [31:0] if_rdata_q;
  dm_resp_t    dm_resp_q;

  rom_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .dm_req   (dm_req),
    .dm_gnt   (dm_gnt),
    .force_dm (force_dm)
  );

  assign dm_gnt   = dm_req && (!if_req || force_dm);
  assign if_gnt   = if_req && !dm_gnt;
  assign rom_addr = dm_gnt ? dm_addr : if_addr;

  assign if_oor = (32'(if_addr) >= ADDR_LIMIT);
  assign dm_bad = (dm_addr[1:0] != 2'b00) || (32'(dm_addr) >= ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_q    <= GNT_NONE;
      if_rdata_q <= RV_NOP;
      dm_resp_q  <= '0;
    end else if (if_gnt) begin
      grant_q    <= GNT_IF;
      if_rdata_q <= if_oor ? RV_NOP : rom_inst;
    end else if (dm_gnt) begin
      grant_q    <= GNT_DM;
      dm_resp_q  <= dm_bad ? dm_resp_t'{err: 1'b1, dat: 32'h0}
                           : dm_resp_t'{err: 1'b0, dat: rom_inst};
    end else begin
      grant_q    <= GNT_NONE;
    end
  end

  assign if_rvalid = (grant_q == GNT_IF);
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = (grant_q == GNT_DM);
  assign dm_rdata  = dm_resp_q.dat;
  // The error flag only means something alongside its response pulse.
  assign dm_err    = dm_rvalid && dm_resp_q.err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: vector table of grants plus a response scoreboard.
module tb_rom_port_arbiter;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic [11:0] dm_addr = '0;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_rdata;
  logic [11:0] rom_addr;
  logic [31:0] rom_inst;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(logic [11:0] a);
    return 32'hC000_0000 | ({22'd0, a[11:2]} * 32'h0001_0101);
  endfunction

  assign rom_inst = rom_word(rom_addr);

  rom_port_arbiter #(
    .ADDR_W   (12),
    .DEPTH    (128),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst)
  );

  typedef struct {
    logic        ir;
    logic [11:0] ia;
    logic        dr;
    logic [11:0] da;
    logic        eif;
    logic        edm;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] if_q[$];
  logic [32:0] dm_q[$];
  logic [31:0] last_if;
  logic [31:0] last_dm;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cur_row  = -1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (row %0d): got %h expected %h", name, cur_row, act, exp);
  endtask

  task automatic chkb(string name, logic act, logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (row %0d): got %b expected %b", name, cur_row, act, exp);
  endtask

  function automatic logic [31:0] exp_if(logic [11:0] a);
    return (a >= 12'h200) ? NOP : rom_word(a);
  endfunction

  function automatic logic [32:0] exp_dm(logic [11:0] a);
    logic bad;
    bad = (a[1:0] != 2'b00) || (a >= 12'h200);
    return bad ? {1'b1, 32'h0} : {1'b0, rom_word(a)};
  endfunction

  // Registered outputs after the edge: pop a response if one is owed, else expect idle and held data.
  task automatic check_responses();
    logic [32:0] d;
    @(posedge clk);
    #1;
    if (if_q.size() > 0) begin
      last_if = if_q.pop_front();
      chkb("if_rvalid", if_rvalid, 1'b1);
      chk("if_rdata", if_rdata, last_if);
    end else begin
      chkb("if_rvalid_idle", if_rvalid, 1'b0);
      chk("if_rdata_hold", if_rdata, last_if);
    end
    if (dm_q.size() > 0) begin
      d = dm_q.pop_front();
      last_dm = d[31:0];
      chkb("dm_rvalid", dm_rvalid, 1'b1);
      chkb("dm_err", dm_err, d[32]);
      chk("dm_rdata", dm_rdata, last_dm);
    end else begin
      chkb("dm_rvalid_idle", dm_rvalid, 1'b0);
      chkb("dm_err_idle", dm_err, 1'b0);
      chk("dm_rdata_hold", dm_rdata, last_dm);
    end
  endtask

  task automatic drive(vec_t v);
    @(negedge clk);
    if_req  = v.ir;
    if_addr = v.ia;
    dm_req  = v.dr;
    dm_addr = v.da;
    #1;
    chkb("if_gnt", if_gnt, v.eif);
    chkb("dm_gnt", dm_gnt, v.edm);
    if (v.eif) if_q.push_back(exp_if(v.ia));
    if (v.edm) dm_q.push_back(exp_dm(v.da));
    check_responses();
  endtask

  initial begin
    // fetch only, back to back
    vecs.push_back('{1'b1, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h004, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h008, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0});
    // data only, then errors and range boundaries
    vecs.push_back('{1'b0, 12'h000, 1'b1, 12'h008, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 12'h006, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 12'h200, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 12'h1FC, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12'h000, 1'b1, 12'h1FF, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 12'h200, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h1FC, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'hFFC, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0});
    // contention: four fetch wins, then the starved load goes through
    vecs.push_back('{1'b1, 12'h010, 1'b1, 12'h020, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h014, 1'b1, 12'h020, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h018, 1'b1, 12'h020, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h01C, 1'b1, 12'h020, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h020, 1'b1, 12'h020, 1'b0, 1'b1});
    // counter cleared by the grant: four more fetch wins needed
    vecs.push_back('{1'b1, 12'h020, 1'b1, 12'h030, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h024, 1'b1, 12'h030, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h028, 1'b1, 12'h030, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h02C, 1'b1, 12'h030, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h030, 1'b1, 12'h030, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 12'h030, 1'b0, 12'h000, 1'b1, 1'b0});
    // counter cleared when the load request drops
    vecs.push_back('{1'b1, 12'h034, 1'b1, 12'h040, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h038, 1'b0, 12'h040, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h03C, 1'b1, 12'h040, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h040, 1'b1, 12'h040, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h044, 1'b1, 12'h040, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h048, 1'b1, 12'h040, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 12'h04C, 1'b1, 12'h040, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 12'h04C, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_if_rvalid", if_rvalid, 1'b0);
    chkb("rst_dm_rvalid", dm_rvalid, 1'b0);
    chkb("rst_dm_err", dm_err, 1'b0);
    chk("rst_if_rdata", if_rdata, NOP);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    last_if = NOP;
    last_dm = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cur_row = i;
      drive(vecs[i]);
    end

    // reset lands on the edge that would register a granted load
    cur_row = 1000;
    @(negedge clk);
    if_req  = 1'b0;
    dm_req  = 1'b1;
    dm_addr = 12'h008;
    #1;
    chkb("pre_rst_dm_gnt", dm_gnt, 1'b1);
    reset_n = 1'b0;
    #1;
    chkb("rst_cycle_dm_gnt", dm_gnt, 1'b1);
    @(posedge clk);
    #1;
    chkb("midrst_dm_rvalid", dm_rvalid, 1'b0);
    chkb("midrst_if_rvalid", if_rvalid, 1'b0);
    chkb("midrst_dm_err", dm_err, 1'b0);
    chk("midrst_dm_rdata", dm_rdata, 32'h0);
    chk("midrst_if_rdata", if_rdata, NOP);
    if_q.delete();
    dm_q.delete();
    last_if = NOP;
    last_dm = 32'h0;
    @(negedge clk);
    reset_n = 1'b1;
    dm_req  = 1'b0;
    cur_row = 1001;
    drive('{1'b1, 12'h00C, 1'b0, 12'h000, 1'b1, 1'b0});
    cur_row = 1002;
    drive('{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
